// File: rtl/xmint_pkg.sv
// Shared types and helpers for the xmint instruction fetch stage.
package xmint_pkg;

  localparam logic [0:0] FETCH_IDLE = 1'b0;
  localparam logic [0:0] FETCH_REQ  = 1'b1;

  localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] rdata;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  // Hsiao SECDED(39,32) check bits
  function automatic logic [6:0] secded_39_32_enc(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606_BD25);
    c[1] = ^(d & 32'hDEBA_8050);
    c[2] = ^(d & 32'h413D_89AA);
    c[3] = ^(d & 32'h3123_4ED1);
    c[4] = ^(d & 32'hC2C1_323B);
    c[5] = ^(d & 32'h2DCC_624C);
    c[6] = ^(d & 32'h9850_5586);
    return c;
  endfunction

endpackage

// File: rtl/xmint_fetch_fifo.sv
// Synchronous FIFO with flush; push and pop may coincide, including when full.
module xmint_fetch_fifo
  import xmint_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = FETCH_ENTRY_W,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == CW'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count_o <= count_o + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/xmint_if_stage.sv
// xmint instruction fetch: OBI request FSM, per-request PC queue, prefetch FIFO.
// Optional response integrity check enabled by XMINT_FETCH_INTG_CHECK_EN.
module xmint_if_stage
  import xmint_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter bit          RESET_HALT = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] boot_addr_i,
  input  logic        fetch_enable_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic [6:0]  instr_rdata_intg_i,
  input  logic        instr_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_pc_o,
  output logic        fetch_err_o
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [0:0]    state_q, state_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d, req_addr_q, req_addr_d, base_addr;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic          halted_q, halted_d;
  logic          gnt_fire, resp_err, push, pop, issue_ok, head_valid, fifo_empty;
  logic [31:0]   resp_pc;
  fetch_entry_t  push_entry, head;
  logic          fifo_full_unused, pcq_full_unused, pcq_empty_unused;
  logic [CW-1:0] pcq_cnt_unused;

`ifdef XMINT_FETCH_INTG_CHECK_EN
  assign resp_err = instr_err_i | (secded_39_32_enc(instr_rdata_i) != instr_rdata_intg_i);
`else
  logic intg_unused;
  assign intg_unused = ^instr_rdata_intg_i;
  assign resp_err    = instr_err_i;
`endif

  assign gnt_fire   = (state_q == FETCH_REQ) & instr_gnt_i;
  assign head_valid = ~fifo_empty;
  // Responses arriving while discards are pending, or during a redirect, are stale.
  assign push       = instr_rvalid_i & (disc_q == '0) & ~redirect_i;
  assign pop        = head_valid & fetch_ready_i & ~redirect_i;
  assign push_entry = '{err: resp_err, pc: resp_pc, rdata: instr_rdata_i};

  assign cnt_d    = redirect_i ? '0 : cnt_q + CW'(push) - CW'(pop);
  assign out_d    = out_q + CW'(gnt_fire) - CW'(instr_rvalid_i);
  assign halted_d = redirect_i ? 1'b0 : ((push & resp_err) ? 1'b1 : halted_q);
  assign issue_ok = fetch_enable_i & ~halted_d &
                    (({1'b0, cnt_d} + {1'b0, out_d}) < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    disc_d = disc_q;
    if (redirect_i)
      // an un-granted request still in flight is stale as well
      disc_d = out_d + CW'((state_q == FETCH_REQ) & ~instr_gnt_i);
    else if (instr_rvalid_i && disc_q != '0)
      disc_d = disc_q - 1'b1;
  end

  // fetch_addr is the next address to issue; req_addr holds the pending one.
  always_comb begin
    base_addr    = redirect_i ? (redirect_addr_i & INSTR_ALIGN_MASK) : fetch_addr_q;
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    fetch_addr_d = base_addr;
    if ((state_q == FETCH_IDLE || gnt_fire) && issue_ok) begin
      state_d      = FETCH_REQ;
      req_addr_d   = base_addr;
      fetch_addr_d = base_addr + 32'd4;
    end else if (gnt_fire) begin
      state_d = FETCH_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FETCH_IDLE;
      fetch_addr_q <= boot_addr_i & INSTR_ALIGN_MASK;
      req_addr_q   <= boot_addr_i & INSTR_ALIGN_MASK;
      out_q        <= '0;
      disc_q       <= '0;
      halted_q     <= RESET_HALT;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      req_addr_q   <= req_addr_d;
      out_q        <= out_d;
      disc_q       <= disc_d;
      halted_q     <= halted_d;
    end
  end

  xmint_fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(32), .CW(CW)) u_pc_q (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (1'b0),
    .push_i  (gnt_fire),
    .wdata_i (req_addr_q),
    .pop_i   (instr_rvalid_i),
    .rdata_o (resp_pc),
    .full_o  (pcq_full_unused),
    .empty_o (pcq_empty_unused),
    .count_o (pcq_cnt_unused)
  );

  xmint_fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(FETCH_ENTRY_W), .CW(CW)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full_unused),
    .empty_o (fifo_empty),
    .count_o (cnt_q)
  );

  assign instr_req_o   = (state_q == FETCH_REQ);
  assign instr_addr_o  = instr_req_o ? req_addr_q : fetch_addr_q;
  assign fetch_valid_o = head_valid;
  assign fetch_rdata_o = head_valid ? head.rdata : '0;
  assign fetch_pc_o    = head_valid ? head.pc : '0;
  assign fetch_err_o   = head_valid & head.err;

endmodule

// File: tb/tb_xmint_if_stage.sv
// Directed bench for xmint_if_stage with an OBI memory responder and decode-side monitor.
module tb_xmint_if_stage;
  logic        clk, rst_i;
  logic [31:0] boot_addr_i, instr_addr_o, instr_rdata_i, redirect_addr_i;
  logic [31:0] fetch_rdata_o, fetch_pc_o;
  logic [6:0]  instr_rdata_intg_i;
  logic        fetch_enable_i, instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i;
  logic        redirect_i, fetch_valid_o, fetch_ready_i, fetch_err_o;

  logic        gnt_en, rsp_en;
  logic [31:0] err_addr, intg_addr;
  logic [31:0] req_log[$], rsp_q[$], pc_log[$], rd_log[$];
  logic        err_log[$];
  int          n_cmp = 0, n_mis = 0;
  logic        intg_exp;

  xmint_if_stage #(.FIFO_DEPTH(2), .RESET_HALT(1'b0)) dut (
    .clk_i(clk), .rst_i(rst_i), .boot_addr_i(boot_addr_i), .fetch_enable_i(fetch_enable_i),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_rdata_intg_i(instr_rdata_intg_i), .instr_err_i(instr_err_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready_i),
    .fetch_rdata_o(fetch_rdata_o), .fetch_pc_o(fetch_pc_o), .fetch_err_o(fetch_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [31:0] m [7];
    logic [6:0]  c;
    m = '{32'h2606_BD25, 32'hDEBA_8050, 32'h413D_89AA, 32'h3123_4ED1,
          32'hC2C1_323B, 32'h2DCC_624C, 32'h9850_5586};
    for (int i = 0; i < 7; i++) c[i] = ^(d & m[i]);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // memory: response one cycle after grant at the earliest, held while rsp_en=0
  always @(posedge clk) begin : mem_model
    logic [31:0] a;
    #2;
    if (rst_i) begin
      rsp_q.delete();
      instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_err_i = 1'b0;
      instr_rdata_i = '0; instr_rdata_intg_i = '0;
    end else begin
      if (rsp_en && rsp_q.size() > 0) begin
        a = rsp_q.pop_front();
        instr_rvalid_i     = 1'b1;
        instr_rdata_i      = (a == intg_addr) ? 32'h0 : (a ^ 32'hA5A5_0000);
        instr_rdata_intg_i = (a == intg_addr) ? 7'h01 : enc(instr_rdata_i);
        instr_err_i        = (a == err_addr);
      end else begin
        instr_rvalid_i = 1'b0; instr_err_i = 1'b0;
        instr_rdata_i = '0; instr_rdata_intg_i = '0;
      end
      instr_gnt_i = gnt_en;
      if (instr_req_o && instr_gnt_i) begin
        rsp_q.push_back(instr_addr_o);
        req_log.push_back(instr_addr_o);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_i && fetch_valid_o && fetch_ready_i && !redirect_i) begin
      pc_log.push_back(fetch_pc_o);
      rd_log.push_back(fetch_rdata_o);
      err_log.push_back(fetch_err_o);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] boot);
    rst_i = 1'b1; boot_addr_i = boot; fetch_enable_i = 1'b0; fetch_ready_i = 1'b0;
    redirect_i = 1'b0; redirect_addr_i = '0; gnt_en = 1'b0; rsp_en = 1'b1;
    err_addr = 32'h1; intg_addr = 32'h1;
    req_log.delete(); pc_log.delete(); rd_log.delete(); err_log.delete();
    step(2);
  endtask

  task automatic redirect(input logic [31:0] a);
    redirect_i = 1'b1; redirect_addr_i = a;
    step(1);
    redirect_i = 1'b0;
  endtask

  initial begin
    int n;
    rst_i = 1'b1; boot_addr_i = '0; fetch_enable_i = 1'b0; fetch_ready_i = 1'b0;
    redirect_i = 1'b0; redirect_addr_i = '0; gnt_en = 1'b0; rsp_en = 1'b1;
    err_addr = 32'h1; intg_addr = 32'h1;

    // reset state and sequential fetch from a misaligned boot address
    do_reset(32'h0000_1002);
    chk("rst_req",   {31'b0, instr_req_o},   32'h0);
    chk("rst_valid", {31'b0, fetch_valid_o}, 32'h0);
    chk("rst_err",   {31'b0, fetch_err_o},   32'h0);
    chk("rst_rdata", fetch_rdata_o,          32'h0);
    chk("rst_pc",    fetch_pc_o,             32'h0);
    chk("rst_addr",  instr_addr_o,           32'h0000_1000);
    rst_i = 1'b0; gnt_en = 1'b1; fetch_ready_i = 1'b1; fetch_enable_i = 1'b1;
    step(15);
    fetch_enable_i = 1'b0;
    step(6);
    chk("seq_addr0", req_log[0], 32'h1000);
    chk("seq_addr1", req_log[1], 32'h1004);
    chk("seq_addr2", req_log[2], 32'h1008);
    chk("seq_pc0",   pc_log[0],  32'h1000);
    chk("seq_pc1",   pc_log[1],  32'h1004);
    chk("seq_pc2",   pc_log[2],  32'h1008);
    chk("seq_rd0",   rd_log[0],  32'hA5A5_1000);
    chk("seq_err0",  {31'b0, err_log[0]}, 32'h0);
    chk("seq_drain", 32'(pc_log.size()), 32'(req_log.size()));
    n = req_log.size();
    step(5);
    chk("en_low_noreq", 32'(req_log.size()), 32'(n));

    // backpressure: depth 2 bounds the number of granted requests
    do_reset(32'h0000_1000);
    rst_i = 1'b0; gnt_en = 1'b1; fetch_enable_i = 1'b1;
    step(12);
    chk("bp_nreq",  32'(req_log.size()), 32'd2);
    chk("bp_req",   {31'b0, instr_req_o}, 32'h0);
    chk("bp_valid", {31'b0, fetch_valid_o}, 32'h1);
    chk("bp_pc",    fetch_pc_o, 32'h1000);
    fetch_ready_i = 1'b1;
    step(1);
    fetch_ready_i = 1'b0;
    step(6);
    chk("bp_nreq_pop", 32'(req_log.size()), 32'd3);
    chk("bp_addr2",    req_log[2], 32'h1008);

    // redirect with two outstanding responses
    do_reset(32'h0000_1000);
    rst_i = 1'b0; gnt_en = 1'b1; rsp_en = 1'b0; fetch_ready_i = 1'b1; fetch_enable_i = 1'b1;
    step(6);
    chk("rd2_nreq", 32'(req_log.size()), 32'd2);
    redirect(32'h0000_2000);
    rsp_en = 1'b1;
    step(10);
    chk("rd2_addr2", req_log[2], 32'h2000);
    chk("rd2_pc0",   pc_log[0],  32'h2000);
    chk("rd2_pc1",   pc_log[1],  32'h2004);

    // redirect while a request waits for grant
    do_reset(32'h0000_1000);
    rst_i = 1'b0; fetch_ready_i = 1'b1; fetch_enable_i = 1'b1;
    step(2);
    chk("wait_req",  {31'b0, instr_req_o}, 32'h1);
    chk("wait_addr", instr_addr_o, 32'h1000);
    redirect(32'h0000_2003);
    chk("wait_addr_held", instr_addr_o, 32'h1000);
    step(1);
    chk("wait_addr_held2", instr_addr_o, 32'h1000);
    gnt_en = 1'b1;
    step(8);
    chk("wait_addr0", req_log[0], 32'h1000);
    chk("wait_addr1", req_log[1], 32'h2000);
    chk("wait_pc0",   pc_log[0],  32'h2000);

    // bus error halts fetching until a redirect
    do_reset(32'h0000_1000);
    rst_i = 1'b0; gnt_en = 1'b1; fetch_ready_i = 1'b1; fetch_enable_i = 1'b1;
    err_addr = 32'h1004;
    step(8);
    chk("err_pc1",  pc_log[1], 32'h1004);
    chk("err_err1", {31'b0, err_log[1]}, 32'h1);
    chk("err_err0", {31'b0, err_log[0]}, 32'h0);
    step(10);
    chk("err_halt_req",  {31'b0, instr_req_o}, 32'h0);
    chk("err_halt_nreq", 32'(req_log.size()), 32'd2);
    redirect(32'h0000_3000);
    step(4);
    chk("err_resume", req_log[2], 32'h3000);

    // integrity: data 0 has check bits 0; bit 0 flipped
    do_reset(32'h0000_1000);
    rst_i = 1'b0; gnt_en = 1'b1; fetch_ready_i = 1'b1; fetch_enable_i = 1'b1;
    intg_addr = 32'h1000;
`ifdef XMINT_FETCH_INTG_CHECK_EN
    intg_exp = 1'b1;
`else
    intg_exp = 1'b0;
`endif
    step(6);
    chk("intg_pc",  pc_log[0], 32'h1000);
    chk("intg_rd",  rd_log[0], 32'h0);
    chk("intg_err", {31'b0, err_log[0]}, {31'b0, intg_exp});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/xmint_if_stage.md
Name: xmint_if_stage

Overview:
Instruction fetch stage of the xmint core: it drives the core's OBI-style instruction memory interface (req/gnt/rvalid) and buffers returned words in a small prefetch FIFO. It presents words, with their PCs, to the decode stage through a valid/ready handshake. It sits between the instruction memory port of xmint_top and the decoder, and handles control-flow redirects by flushing the buffer and dropping stale responses.

Parameters:
FIFO_DEPTH, 2, prefetch entries (power of 2, ≥2); also the bound on buffered + outstanding fetches
RESET_HALT, 0, 1 = stay idle after reset until first redirect_i

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous active-high reset
boot_addr_i  in  32  fetch start address, sampled during reset
fetch_enable_i  in  1  1 = new requests may be issued
instr_req_o  out  1  OBI request
instr_gnt_i  in  1  OBI grant
instr_addr_o  out  32  word-aligned fetch address
instr_rvalid_i  in  1  response valid
instr_rdata_i  in  32  response data
instr_rdata_intg_i  in  7  response integrity bits
instr_err_i  in  1  bus error on response
redirect_i  in  1  branch/jump/trap redirect, one-cycle pulse
redirect_addr_i  in  32  redirect target
fetch_valid_o  out  1  FIFO head valid
fetch_ready_i  in  1  decode consumes head
fetch_rdata_o  out  32  head instruction word
fetch_pc_o  out  32  head PC
fetch_err_o  out  1  head carries fetch error

Behaviour:
- Reset (rst_i high at clk edge): fetch_addr <= {boot_addr_i[31:2],2'b00}; FIFO empty; outstanding=0; discard=0; halted=RESET_HALT; state IDLE. Outputs: instr_req_o=0, fetch_valid_o=0, fetch_err_o=0, fetch_rdata_o=0, fetch_pc_o=0; instr_addr_o=fetch_addr.
- FSM IDLE/REQ. IDLE->REQ when fetch_enable_i & !halted & (count+outstanding) < FIFO_DEPTH. In REQ: instr_req_o=1, instr_addr_o held stable until gnt. On gnt: outstanding+1, fetch_addr += 4 (wraps 0xFFFF_FFFC->0), remain in REQ if issue condition still holds, else IDLE. Back-to-back grants allowed: one request per cycle max.
- Response (instr_rvalid_i): outstanding-1. If discard>0: discard-1, data dropped. Else push {rdata, pc, err}. Response PCs are tracked in a per-request PC queue; responses return in order.
- Earliest decode visibility: one cycle after rvalid (FIFO registered). Head pop when fetch_valid_o & fetch_ready_i; push and pop in the same cycle allowed, including when full.
- Error: pushed entry with err=1 sets halted; no new requests until redirect_i. Already-outstanding responses still buffered.
- Redirect (priority over everything except reset): FIFO flushed; fetch_addr <= {redirect_addr_i[31:2],2'b00}; halted cleared; discard <= outstanding after this cycle's gnt/rvalid updates, excluding this cycle's response. Any same-cycle rvalid data is dropped. Any same-cycle pop is ignored.
- Redirect while REQ && !gnt: the pending request keeps its address until granted and is counted as discard. The new address is issued on the next request.
- fetch_enable_i low: no new requests; a pending un-granted request stays asserted. Outstanding responses are still accepted.
- Reset mid-transaction returns to reset state; any late responses are ignored only via the bus protocol (system reset).

Optional Feature:
XMINT_FETCH_INTG_CHECK_EN
- Defined: recompute 7-bit SECDED(39,32) check bits of instr_rdata_i and compare with instr_rdata_intg_i. A mismatch is ORed into the entry's err flag (same halt behaviour as instr_err_i).
- Undefined: instr_rdata_intg_i ignored; err = instr_err_i only.

Decomposition:
- Package xmint_pkg: fetch FSM state enum; secded_39_32_enc function; INSTR_ALIGN_MASK constant; FETCH_ENTRY_W.
- One sub-module: xmint_fetch_fifo, a synchronous FIFO with flush, push/pop, full/empty and count, holding {err, pc, rdata}.

Test Plan:
- boot_addr_i=0x0000_1002, gnt tied 1, rvalid one cycle after gnt -> instr_addr_o sequence 0x1000, 0x1004, 0x1008; PCs out in order.
- fetch_ready_i=0, FIFO_DEPTH=2 -> exactly 2 requests granted, then instr_req_o=0 until a pop.
- Two outstanding, redirect_i to 0x2000 -> both responses dropped; first delivered PC is 0x2000.
- gnt withheld 3 cycles, redirect mid-wait -> instr_addr_o stays at the old value until gnt; that response is discarded; next request is 0x2000.
- instr_err_i on PC 0x1004 -> fetch_err_o=1 with fetch_pc_o=0x1004; no requests until redirect.
- Macro defined, intg bit 0 flipped -> fetch_err_o=1. Macro undefined -> fetch_err_o=0.
